mem_access_unit: RTL
====================

# mem_access_unit

Load/store front end between the processor's MEM stage and `MemoryModule`. It accepts one byte-addressed request at a time over a valid/ready handshake and converts it into `MemoryModule`'s word-addressed `rd`/`wr` strobe protocol. Sub-word stores are done as read-modify-write; sub-word loads are lane-aligned and sign- or zero-extended. The result is returned as a single-cycle response pulse.

## Interface
- `RD_WAIT`, default 1: cycles `mem_rd` is held high before read data is sampled (≥1).
- `WR_HOLD`, default 1: cycles `mem_wr` is held high per write (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend sub-word loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; sub-word data in low bits.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  request rejected; qualified by `rsp_valid`.
- `mem_address`  out  28  word address to `MemoryModule.address`.
- `mem_data`  out  32  write data to `MemoryModule.data`.
- `mem_wr`  out  1  to `MemoryModule.wr`.
- `mem_rd`  out  1  to `MemoryModule.rd`.
- `mem_rst`  out  1  to `MemoryModule.rst`; combinational `~rst_n`.
- `mem_rdata`  in  32  from `MemoryModule.data1`.

## Operation
- States: IDLE, READ, MERGE, WRITE, RESP.
- `req_ready` = 1 only in IDLE. A request is accepted on the edge where `req_valid && req_ready`. All request fields are registered at acceptance.
- Error check at acceptance:
  - Error conditions: `req_size`=11, half with `addr[0]`=1, word with `addr[1:0]`≠0, or `addr[31:30]`≠0.
  - On error: IDLE→RESP with `rsp_err`=1, `rsp_rdata`=0, and no memory strobe.
- `mem_address` = `addr[29:2]`. `mem_address` and `mem_data` are stable for the whole transaction and hold their last values in IDLE.
- Load: IDLE→READ (`mem_rd`=1 for RD_WAIT cycles)→RESP.
  - `mem_rdata` is sampled on the edge that ends the last READ cycle.
  - Byte lane is `addr[1:0]`; half lane is `addr[1]`.
  - Sign-extend unless `req_unsigned`.
- Word store: IDLE→WRITE (`mem_wr`=1 for WR_HOLD cycles, `mem_data`=wdata)→RESP.
- Sub-word store: IDLE→READ→MERGE→WRITE→RESP.
  - MERGE replaces only the addressed byte/half of the sampled word. Strobes are low in MERGE.
- RESP: `rsp_valid`=1 for exactly one cycle, then →IDLE. There is no response back-pressure.
- `mem_rd` and `mem_wr` are never high together.
- Reset values: `req_ready`=0 while `rst_n`=0, then 1 in IDLE. `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_wr`=0, `mem_rd`=0, `mem_address`=0, `mem_data`=0, `mem_rst`=1.
- Reset mid-transaction: immediate return to IDLE, strobes drop asynchronously, and no response is issued. If reset hits in READ or MERGE of a read-modify-write, no write occurs.

## Timing
- Latency is counted from the accept edge to the cycle in which `rsp_valid` is high:
  - error: 1.
  - load: RD_WAIT+1 (2 at default).
  - word store: WR_HOLD+1 (2 at default).
  - sub-word store: RD_WAIT+WR_HOLD+2 (4 at default).
- Next accept is possible on the edge ending the RESP cycle's successor (IDLE). Back-to-back throughput is one request per latency+1 cycles.
- Wait counter: width `$clog2(max(RD_WAIT,WR_HOLD)+1)`. It loads on state entry and decrements to 0; the state exits when it reaches 0.

## Structure
- Package `mem_access_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state enum `ma_state_t`;
  - `MEM_AW`=28 and `DATA_W`=32.
- Sub-module `mem_lane_align` (combinational) provides:
  - load extract/extend from `(word, addr[1:0], size, unsigned)`;
  - store merge from `(old_word, wdata, addr[1:0], size)`.
- The top level holds the FSM, request registers, wait counter and output registers.

## Test plan
- After reset, word store `0xA5A5A5A5` @ 0x14, then word load @ 0x14:
  - `mem_address`=5;
  - `mem_wr` high 1 cycle;
  - load returns `0xA5A5A5A5` at latency 2, `rsp_err`=0.
- Memory word 5 = `0x11223344`:
  - byte load @ 0x17 signed → `0x00000011`;
  - half load @ 0x16 → `0x00001122`;
  - byte store `0xFF` @ 0x15 → word becomes `0x1122FF44` via READ/MERGE/WRITE, `rsp_valid` at cycle 4;
  - signed byte load @ 0x15 → `0xFFFFFFFF`.
- Misaligned half @ 0x15, word @ 0x16, size 11, and addr `0x40000000`:
  - each gives `rsp_err`=1 and `rsp_rdata`=0 at latency 1;
  - `mem_rd`/`mem_wr` never assert.
- Assert `rst_n`=0 during MERGE of a byte store:
  - strobes drop immediately, no `rsp_valid`, memory word unchanged;
  - `req_ready`=1 on the first cycle after reset release.
- RD_WAIT=3, WR_HOLD=2:
  - `mem_rd` high exactly 3 cycles and `mem_wr` exactly 2;
  - sub-word store latency is 7;
  - `req_valid` held high continuously is accepted only in IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM state type and request legality check for the
// MEM-stage load/store front end.
package mem_access_pkg;

  localparam int MEM_AW = 28;
  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } ma_state_t;

  // A request is rejected for an illegal size, a misaligned half/word, or an
  // address outside the 1 GiB window that the 28-bit word address can reach.
  function automatic logic req_is_bad(input logic [1:0] size,
                                      input logic [1:0] addr_hi,
                                      input logic [1:0] addr_lo);
    logic bad;
    bad = (addr_hi != 2'b00);
    case (size)
      SZ_BYTE: bad = bad;
      SZ_HALF: bad = bad | addr_lo[0];
      SZ_WORD: bad = bad | (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extracts and extends sub-word load data, and merges
// sub-word store data into a previously read word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] ld_word,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sign_b;
  logic        sign_h;

  // Load path: pick the addressed lane and sign/zero extend it.
  always_comb begin
    byte_v  = ld_word[{addr_lo, 3'b000} +: 8];
    half_v  = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    sign_b  = ~is_unsigned & byte_v[7];
    sign_h  = ~is_unsigned & half_v[15];
    ld_data = '0;
    case (size)
      SZ_BYTE: ld_data = {{24{sign_b}}, byte_v};
      SZ_HALF: ld_data = {{16{sign_h}}, half_v};
      SZ_WORD: ld_data = ld_word;
      default: ld_data = '0;
    endcase
  end

  // Store path: overwrite only the addressed lane of the old word.
  always_comb begin
    st_word = old_word;
    case (size)
      SZ_BYTE: st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) st_word[31:16] = wdata[15:0];
        else            st_word[15:0]  = wdata[15:0];
      end
      SZ_WORD: st_word = wdata;
      default: st_word = old_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: one byte-addressed request at a time, converted to
// word-addressed rd/wr strobes, read-modify-write for sub-word stores and a
// one-cycle response pulse.
//
// Request handshake: a request transfers on the rising edge where
// req_valid && req_ready are both 1. req_ready is high only in IDLE and low
// while rst_n is low. req_valid may be held high; it is ignored outside IDLE.
// The response has no back-pressure: rsp_valid is high for exactly one cycle.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RD_WAIT = 1,
  parameter int WR_HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic              mem_rst,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        dbg_state
);

  localparam int WAIT_MAX = (RD_WAIT > WR_HOLD) ? RD_WAIT : WR_HOLD;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_HOLD - 1);

  ma_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_word_q, rd_word_d;
  logic [MEM_AW-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [31:0]       ld_data;
  logic [31:0]       st_word;

  mem_lane_align u_align (
    .ld_word     (mem_rdata),
    .old_word    (rd_word_q),
    .wdata       (wdata_q),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  // Next-state and next-output logic; strobes follow the next state so they
  // are registered and glitch-free.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    addr_lo_d     = addr_lo_q;
    wdata_d       = wdata_q;
    rd_word_d     = rd_word_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata;
          if (req_is_bad(req_size, req_addr[31:30], req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            mem_address_d = req_addr[29:2];
            if (req_we && (req_size == SZ_WORD)) begin
              mem_data_d = req_wdata;
              state_d    = ST_WRITE;
              cnt_d      = WR_LOAD;
            end else begin
              state_d = ST_READ;
              cnt_d   = RD_LOAD;
            end
          end
        end
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          if (we_q) begin
            rd_word_d = mem_rdata;
            state_d   = ST_MERGE;
          end else begin
            rsp_rdata_d = ld_data;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_MERGE: begin
        mem_data_d = st_word;
        state_d    = ST_WRITE;
        cnt_d      = WR_LOAD;
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mem_rd_d = (state_d == ST_READ);
    mem_wr_d = (state_d == ST_WRITE);
  end

  // All state and outputs; async reset drops strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      size_q        <= SZ_BYTE;
      uns_q         <= 1'b0;
      addr_lo_q     <= 2'b00;
      wdata_q       <= '0;
      rd_word_q     <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      addr_lo_q     <= addr_lo_d;
      wdata_q       <= wdata_d;
      rd_word_q     <= rd_word_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = rst_n & (state_q == ST_IDLE);
  assign mem_rst     = ~rst_n;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state   = state_q;

endmodule
